// File: rtl/sram_like_bridge.sv
// rtl/sram_like_bridge.sv - CPU to SRAM-like bus bridge, one outstanding access; optional WAIT timeout via SRAML_TIMEOUT_EN
module sram_like_bridge (
   input  logic        clk,
   input  logic        rst,
   input  logic        cpu_en,
   input  logic [3:0]  cpu_wen,
   input  logic [31:0] cpu_addr,
   input  logic [31:0] cpu_wdata,
   output logic [31:0] cpu_rdata,
   output logic        cpu_stall,
   input  logic        longest_stall,
   output logic        req,
   output logic        wr,
   output logic [1:0]  size,
   output logic [31:0] addr,
   output logic [31:0] wdata,
   input  logic        addr_ok,
   input  logic        data_ok,
   input  logic [31:0] rdata,
   output logic        bus_err
);

   typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DONE} state_t;

   state_t      state_q, state_d;
   logic [31:0] cpu_rdata_q, cpu_rdata_d;
`ifdef SRAML_TIMEOUT_EN
   logic [7:0]  cnt_q, cnt_d;
   logic        bus_err_q, bus_err_d;
`endif

   // Bus request side and CPU stall, straight from the CPU inputs and state
   always_comb begin
      req       = cpu_en & (state_q == S_IDLE);
      wr        = |cpu_wen;
      addr      = cpu_addr;
      wdata     = cpu_wdata;
      cpu_stall = cpu_en & (state_q != S_DONE);
      cpu_rdata = cpu_rdata_q;
   end

   // Transfer size from the byte-enable pattern; odd patterns fall back to word
   always_comb begin
      case (cpu_wen)
         4'b0011, 4'b1100:                   size = 2'd1;
         4'b0001, 4'b0010, 4'b0100, 4'b1000: size = 2'd0;
         default:                            size = 2'd2;
      endcase
   end

   // Next state, response capture and (optionally) the WAIT timeout
   always_comb begin
      state_d     = state_q;
      cpu_rdata_d = cpu_rdata_q;
`ifdef SRAML_TIMEOUT_EN
      cnt_d       = cnt_q;
      bus_err_d   = 1'b0;
`endif
      case (state_q)
         S_IDLE: begin
            // data_ok here is a stray response and is ignored
            if (req && addr_ok) begin
               state_d = S_WAIT;
`ifdef SRAML_TIMEOUT_EN
               cnt_d   = 8'd0;
`endif
            end
         end
         S_WAIT: begin
            if (data_ok) begin
               state_d     = S_DONE;
               cpu_rdata_d = rdata;
`ifdef SRAML_TIMEOUT_EN
            end else if (cnt_q == 8'd254) begin
               // 255th WAIT cycle without a response
               state_d     = S_DONE;
               cpu_rdata_d = 32'h0;
               bus_err_d   = 1'b1;
            end else begin
               cnt_d = cnt_q + 8'd1;
`endif
            end
         end
         S_DONE: begin
            if (!longest_stall) begin
               state_d = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

`ifdef SRAML_TIMEOUT_EN
   assign bus_err = bus_err_q;
`else
   assign bus_err = 1'b0;
`endif

   // State and captured data registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= S_IDLE;
         cpu_rdata_q <= 32'h0;
      end else begin
         state_q     <= state_d;
         cpu_rdata_q <= cpu_rdata_d;
      end
   end

`ifdef SRAML_TIMEOUT_EN
   // Timeout counter and error pulse registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q     <= 8'd0;
         bus_err_q <= 1'b0;
      end else begin
         cnt_q     <= cnt_d;
         bus_err_q <= bus_err_d;
      end
   end
`endif

endmodule

// File: tb/tb_sram_like_bridge.sv
// tb/tb_sram_like_bridge.sv - randomized transaction-level check of sram_like_bridge
module tb_sram_like_bridge;

   logic        clk = 1'b0;
   logic        rst;
   logic        cpu_en;
   logic [3:0]  cpu_wen;
   logic [31:0] cpu_addr;
   logic [31:0] cpu_wdata;
   logic [31:0] cpu_rdata;
   logic        cpu_stall;
   logic        longest_stall;
   logic        req;
   logic        wr;
   logic [1:0]  size;
   logic [31:0] addr;
   logic [31:0] wdata;
   logic        addr_ok;
   logic        data_ok;
   logic [31:0] rdata;
   logic        bus_err;

   int          n_cmp = 0;
   int          n_bad = 0;
   logic [31:0] exp_rdata;

   sram_like_bridge dut (
      .clk(clk), .rst(rst), .cpu_en(cpu_en), .cpu_wen(cpu_wen), .cpu_addr(cpu_addr),
      .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall),
      .longest_stall(longest_stall), .req(req), .wr(wr), .size(size), .addr(addr),
      .wdata(wdata), .addr_ok(addr_ok), .data_ok(data_ok), .rdata(rdata), .bus_err(bus_err)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   function automatic logic [1:0] ref_size(input logic [3:0] w);
      if (w == 4'h0 || w == 4'hF) return 2'd2;
      if (w == 4'h3 || w == 4'hC) return 2'd1;
      if ($countones(w) == 1)     return 2'd0;
      return 2'd2;
   endfunction

   // Sample everything at the falling edge, then advance to just after the next rising edge
   task automatic check_cycle(input logic exp_req, input logic exp_stall);
      @(negedge clk);
      chk("req", req, exp_req);
      chk("cpu_stall", cpu_stall, exp_stall);
      chk("wr", wr, |cpu_wen);
      chk("size", size, ref_size(cpu_wen));
      chk("addr", addr, cpu_addr);
      chk("wdata", wdata, cpu_wdata);
      chk("cpu_rdata", cpu_rdata, exp_rdata);
      chk("bus_err", bus_err, 1'b0);
      @(posedge clk);
      #1;
   endtask

   // One complete access: na cycles before addr_ok, nd WAIT cycles before data_ok, nh DONE hold cycles
   task automatic run_txn(input logic [3:0] wen, input logic [31:0] a, input logic [31:0] wd,
                          input logic [31:0] rd, input int na, input int nd, input int nh);
      cpu_en = 1'b1; cpu_wen = wen; cpu_addr = a; cpu_wdata = wd; longest_stall = 1'b0;
      for (int i = 0; i < na; i++) begin
         addr_ok = 1'b0; data_ok = 1'($urandom); rdata = $urandom;
         check_cycle(1'b1, 1'b1);
      end
      addr_ok = 1'b1; data_ok = 1'($urandom); rdata = $urandom;
      check_cycle(1'b1, 1'b1);
      for (int i = 0; i < nd; i++) begin
         addr_ok = 1'($urandom); data_ok = 1'b0; rdata = $urandom;
         check_cycle(1'b0, 1'b1);
      end
      addr_ok = 1'b0; data_ok = 1'b1; rdata = rd;
      check_cycle(1'b0, 1'b1);
      exp_rdata = rd;
      longest_stall = 1'b1;
      for (int i = 0; i < nh; i++) begin
         data_ok = 1'($urandom); rdata = $urandom;
         check_cycle(1'b0, 1'b0);
      end
      longest_stall = 1'b0; data_ok = 1'b0;
      check_cycle(1'b0, 1'b0);
      cpu_en = 1'b0; addr_ok = 1'($urandom); data_ok = 1'($urandom); rdata = $urandom;
      check_cycle(1'b0, 1'b0);
      addr_ok = 1'b0; data_ok = 1'b0;
   endtask

   task automatic reset_mid_wait();
      cpu_en = 1'b1; cpu_wen = 4'h0; cpu_addr = 32'h0000_1000; cpu_wdata = 32'h0;
      addr_ok = 1'b1; data_ok = 1'b0;
      check_cycle(1'b1, 1'b1);
      addr_ok = 1'b0;
      check_cycle(1'b0, 1'b1);
      #1 rst = 1'b1;
      #1 rst = 1'b0;
      exp_rdata = 32'h0;
      check_cycle(1'b1, 1'b1);
      cpu_en = 1'b0; data_ok = 1'b1; rdata = 32'hDEAD_BEEF;
      check_cycle(1'b0, 1'b0);
      data_ok = 1'b0;
      check_cycle(1'b0, 1'b0);
   endtask

   task automatic timeout_case();
      int waits = 0;
      int pulses = 0;
      int odd = 0;
      logic done = 1'b0;
      logic err_at_done = 1'b0;
      cpu_en = 1'b1; cpu_wen = 4'h0; cpu_addr = 32'h0000_2000; longest_stall = 1'b0;
      addr_ok = 1'b1; data_ok = 1'b0;
      check_cycle(1'b1, 1'b1);
      addr_ok = 1'b0;
`ifdef SRAML_TIMEOUT_EN
      for (int i = 0; i < 400 && !done; i++) begin
         @(negedge clk);
         if (bus_err) pulses++;
         if (!cpu_stall) begin
            done = 1'b1;
            err_at_done = bus_err;
            chk("timeout_rdata", cpu_rdata, 32'h0);
         end else begin
            waits++;
         end
         @(posedge clk);
         #1;
      end
      chk("timeout_done", done, 1'b1);
      chk("timeout_cycles", waits, 255);
      chk("timeout_err_at_done", err_at_done, 1'b1);
      chk("timeout_pulses", pulses, 1);
      exp_rdata = 32'h0;
      cpu_en = 1'b0;
      check_cycle(1'b0, 1'b0);
`else
      for (int i = 0; i < 300; i++) begin
         @(negedge clk);
         if (bus_err || !cpu_stall || req) odd++;
         @(posedge clk);
         #1;
      end
      chk("no_timeout", odd, 0);
      data_ok = 1'b1; rdata = 32'h1234_5678;
      check_cycle(1'b0, 1'b1);
      exp_rdata = 32'h1234_5678;
      data_ok = 1'b0;
      check_cycle(1'b0, 1'b0);
      cpu_en = 1'b0;
      check_cycle(1'b0, 1'b0);
      chk("unused_flags", {31'h0, done | err_at_done}, pulses);
`endif
   endtask

   initial begin
      rst = 1'b1; cpu_en = 1'b0; cpu_wen = 4'h0; cpu_addr = 32'h0; cpu_wdata = 32'h0;
      longest_stall = 1'b0; addr_ok = 1'b0; data_ok = 1'b0; rdata = 32'h0;
      exp_rdata = 32'h0;
      @(negedge clk);
      chk("rst_cpu_rdata", cpu_rdata, 32'h0);
      chk("rst_bus_err", bus_err, 1'b0);
      chk("rst_req", req, 1'b0);
      chk("rst_stall", cpu_stall, 1'b0);
      @(posedge clk);
      #1 rst = 1'b0;

      // idle with no request: no bus activity, no stall, stray responses ignored
      data_ok = 1'b1; rdata = 32'hFFFF_FFFF;
      check_cycle(1'b0, 1'b0);
      data_ok = 1'b0;

      // word read: addr_ok at cycle 1, data_ok at cycle 3
      run_txn(4'b0000, 32'h1FC0_0000, 32'h0, 32'h3C1D_BFC0, 1, 1, 0);
      // byte store
      run_txn(4'b0100, 32'h0000_0042, 32'h00AB_0000, 32'h0000_0000, 0, 2, 0);
      // hold in DONE for 5 cycles
      run_txn(4'b1111, 32'h8000_0010, 32'hCAFE_F00D, 32'h5555_AAAA, 0, 0, 5);
      // halfword stores
      run_txn(4'b0011, 32'h0000_0100, 32'h0000_1234, 32'h0BAD_0001, 2, 0, 1);
      run_txn(4'b1100, 32'h0000_0102, 32'h5678_0000, 32'h0BAD_0002, 0, 3, 0);

      for (int t = 0; t < 25; t++) begin
         run_txn(4'($urandom), $urandom, $urandom, $urandom,
                 int'($urandom_range(0, 3)), int'($urandom_range(0, 4)), int'($urandom_range(0, 3)));
      end

      reset_mid_wait();
      timeout_case();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
